// File: rtl/ising_ctrl_pkg.sv
// Shared constants for the Ising annealing run controller.
package ising_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_SAMPLE = 2'd3;

    localparam int RUNS_W = 16;

    function automatic int agree_w(input int sample_cycles);
        return $clog2(sample_cycles + 1);
    endfunction

endpackage

// File: rtl/spin_sampler.sv
// Oscillator synchronizer plus per-spin phase-agreement counters.
// Raw counts are exported only when ISING_RUN_STATS_EN is defined.
module spin_sampler
    import ising_ctrl_pkg::*;
#(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 64,
    parameter int CW            = agree_w(SAMPLE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [N-1:0]         osc_in,
`ifdef ISING_RUN_STATS_EN
    output logic [N-1:0][CW-1:0] counts,
`endif
    output logic [N-1:0]         spin_vec
);

    logic [N-1:0]         meta;
    logic [N-1:0]         s;
    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0][CW-1:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            s    <= '0;
        end else begin
            meta <= osc_in;
            s    <= meta;
        end
    end

    // cnt_nx folds in the current sample so the final cycle's vote counts
    always_comb begin
        cnt_nx   = '0;
        spin_vec = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nx[i]   = cnt[i] + CW'(s[i] == s[0]);
            spin_vec[i] = cnt_nx[i] > CW'(SAMPLE_CYCLES / 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt_nx;
        end
    end

`ifdef ISING_RUN_STATS_EN
    assign counts = cnt_nx;
`endif

endmodule

// File: rtl/ising_run_ctrl.sv
// Annealing run sequencer: oscillator reset hold, free run, spin sampling.
// Define ISING_RUN_STATS_EN to add the runs_done / last_agree outputs.
module ising_run_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter int N             = 8,
    parameter int RESET_CYCLES  = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int RUN_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [N-1:0]     osc_in,
    input  logic             host_wready,
    output logic             mat_wready,
    output logic             wr_blocked,
    output logic             ising_rstn,
    output logic             busy,
    output logic             done,
`ifdef ISING_RUN_STATS_EN
    output logic [RUNS_W-1:0] runs_done,
    output logic [N-1:0][agree_w(SAMPLE_CYCLES)-1:0] last_agree,
`endif
    output logic [N-1:0]     spins
);

    localparam int PH_MAX = (RESET_CYCLES > SAMPLE_CYCLES) ?
                            RESET_CYCLES : SAMPLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [PH_W-1:0]  ph_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             ph_zero;
    logic             run_zero;
    logic             accept;
    logic             stop;
    logic             finish;
    logic             smp_clear;
    logic             smp_en;
    logic [N-1:0]     spin_vec;

    assign ph_zero  = (ph_cnt == '0);
    assign run_zero = (run_cnt == '0);
    assign accept   = (state == ST_IDLE) && start && !abort;
    assign stop     = (state != ST_IDLE) && abort;
    assign finish   = (state == ST_SAMPLE) && ph_zero && !abort;

    assign smp_clear = (state == ST_RUN) && run_zero;
    assign smp_en    = (state == ST_SAMPLE);

    assign done       = finish;
    assign mat_wready = host_wready && (state == ST_IDLE);
    assign wr_blocked = host_wready && (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept)   state_nx = ST_HOLD;
                ST_HOLD:   if (ph_zero)  state_nx = ST_RUN;
                ST_RUN:    if (run_zero) state_nx = ST_SAMPLE;
                ST_SAMPLE: if (ph_zero)  state_nx = ST_IDLE;
                default:                 state_nx = ST_IDLE;
            endcase
        end
    end

    // Down-counters hold "cycles remaining minus one" in the current phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ph_cnt     <= '0;
            run_cnt    <= '0;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
            spins      <= '0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != ST_IDLE);
            ising_rstn <= (state_nx == ST_RUN) ||
                          (state_nx == ST_SAMPLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ph_cnt  <= PH_W'(RESET_CYCLES - 1);
                        run_cnt <= (run_cycles == '0) ? '0 :
                                   run_cycles - RUN_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!ph_zero) ph_cnt <= ph_cnt - PH_W'(1);
                end
                ST_RUN: begin
                    if (run_zero) ph_cnt <= PH_W'(SAMPLE_CYCLES - 1);
                    else          run_cnt <= run_cnt - RUN_W'(1);
                end
                ST_SAMPLE: begin
                    if (!ph_zero) ph_cnt <= ph_cnt - PH_W'(1);
                end
                default: ;
            endcase
            if (finish) spins <= spin_vec;
        end
    end

`ifdef ISING_RUN_STATS_EN
    logic [N-1:0][agree_w(SAMPLE_CYCLES)-1:0] counts;

    always_ff @(posedge clk) begin
        if (rst) begin
            runs_done  <= '0;
            last_agree <= '0;
        end else if (finish) begin
            runs_done  <= runs_done + RUNS_W'(1);
            last_agree <= counts;
        end
    end
`endif

    spin_sampler #(
        .N             (N),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .clear    (smp_clear),
        .enable   (smp_en),
        .osc_in   (osc_in),
`ifdef ISING_RUN_STATS_EN
        .counts   (counts),
`endif
        .spin_vec (spin_vec)
    );

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl with a cycle-window reference model.
module tb_ising_run_ctrl;
    import ising_ctrl_pkg::*;

    localparam int N    = 8;
    localparam int RC   = 16;
    localparam int SC   = 64;
    localparam int RW   = 32;
    localparam int CW   = agree_w(SC);
    localparam int MAXC = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [RW-1:0] run_cycles = '0;
    logic [N-1:0]  osc_in = '0;
    logic          host_wready = 1'b0;
    logic          mat_wready;
    logic          wr_blocked;
    logic          ising_rstn;
    logic          busy;
    logic          done;
    logic [N-1:0]  spins;
`ifdef ISING_RUN_STATS_EN
    logic [15:0]           runs_done;
    logic [N-1:0][CW-1:0]  last_agree;
`endif

    ising_run_ctrl #(
        .N             (N),
        .RESET_CYCLES  (RC),
        .SAMPLE_CYCLES (SC),
        .RUN_W         (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .run_cycles  (run_cycles),
        .osc_in      (osc_in),
        .host_wready (host_wready),
        .mat_wready  (mat_wready),
        .wr_blocked  (wr_blocked),
        .ising_rstn  (ising_rstn),
        .busy        (busy),
        .done        (done),
`ifdef ISING_RUN_STATS_EN
        .runs_done   (runs_done),
        .last_agree  (last_agree),
`endif
        .spins       (spins)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           done_cyc;
        logic [N-1:0] spins;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] plan [MAXC];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           have_run = 0;
    int           run_t = 0;
    int           run_end = 0;
    logic [N-1:0] model_spins = '0;
    logic [15:0]  model_runs = '0;
    int           agree_valid = 0;
    logic         bexp, rexp, dexp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Oscillator playback and random host write strobes
    initial begin
        forever begin
            @(posedge clk);
            #1;
            osc_in      = plan[cyc];
            host_wready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every cycle against the run window model
    initial begin
        forever begin
            @(negedge clk);
            bexp = (have_run != 0) && cyc > run_t && cyc <= run_end;
            rexp = (have_run != 0) && cyc >= run_t + RC + 1 &&
                   cyc <= run_end;
            dexp = (exp_q.size() > 0) && (exp_q[0].done_cyc == cyc);
            check("busy", 32'(busy), 32'(bexp));
            check("ising_rstn", 32'(ising_rstn), 32'(rexp));
            check("done", 32'(done), 32'(dexp));
            check("mat_wready", 32'(mat_wready),
                  32'(host_wready & !bexp));
            check("wr_blocked", 32'(wr_blocked),
                  32'(host_wready & bexp));
            check("spins", 32'(spins), 32'(model_spins));
`ifdef ISING_RUN_STATS_EN
            check("runs_done", 32'(runs_done), 32'(model_runs));
            if (agree_valid != 0)
                check("last_agree0", 32'(last_agree[0]), SC);
`endif
            if (dexp) begin
                model_spins = exp_q[0].spins;
                model_runs  = model_runs + 16'd1;
                agree_valid = 1;
                void'(exp_q.pop_front());
            end
            if (rst) begin
                model_spins = '0;
                model_runs  = '0;
                agree_valid = 0;
            end
        end
    end

    // mode 1: fixed pattern; ab_k/rs_k/again_k are cycle offsets from start
    task automatic do_run(input int rc, input int mode, input int ab_k,
                          input int rs_k, input int again_k);
        int t, r, fin, endc, cnt, base;
        int p [N];
        logic [N-1:0] v;
        logic [N-1:0] exp_sp;
        @(posedge clk);
        #1;
        t   = cyc;
        r   = (rc == 0) ? 1 : rc;
        fin = t + RC + r + SC;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 6))
                0: p[i] = 0;
                1: p[i] = 20;
                2: p[i] = 45;
                3: p[i] = 50;
                4: p[i] = 55;
                5: p[i] = 80;
                default: p[i] = 100;
            endcase
        end
        for (int c = t + RC + r + 1; c <= fin; c++) begin
            if (mode == 1) begin
                base = ((c - 2) / 3) % 2;
                v = {N{base[0]}} ^ 8'b1110_1010;
            end else begin
                v[0] = 1'($urandom_range(0, 1));
                for (int i = 1; i < N; i++)
                    v[i] = ($urandom_range(0, 99) < p[i]) ? v[0] : ~v[0];
            end
            plan[c - 2] = v;
        end
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            for (int c = t + RC + r + 1; c <= fin; c++)
                if (plan[c - 2][i] == plan[c - 2][0]) cnt++;
            exp_sp[i] = (cnt > SC / 2);
        end
        endc = fin;
        if (ab_k > 0) endc = t + ab_k;
        if (rs_k > 0) endc = t + rs_k;
        have_run = 1;
        run_t    = t;
        run_end  = endc;
        if (ab_k == 0 && rs_k == 0)
            exp_q.push_back('{done_cyc: fin, spins: exp_sp});
        start      = 1'b1;
        run_cycles = RW'(rc);
        while (cyc < endc + 3) begin
            @(posedge clk);
            #1;
            start      = (again_k > 0) && (cyc == t + again_k);
            abort      = (ab_k > 0) && (cyc == t + ab_k);
            rst        = (rs_k > 0) && (cyc == t + rs_k);
            run_cycles = $urandom;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int rc, r, k;
        for (int i = 0; i < MAXC; i++) plan[i] = N'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        do_run(10, 0, 0, 0, 0);
        do_run(10, 1, 0, 0, 0);
        do_run(0, 0, 0, 0, RC + 1);
        do_run(12, 0, 0, 0, 0);
        do_run(20, 0, RC + 5, 0, 0);
        do_run(8, 0, 0, RC + 8 + 10, 0);

        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        run_cycles = 5;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);

        for (int j = 0; j < 3; j++) do_run(3 + j, 0, 0, 0, 0);

        for (int j = 0; j < 20; j++) begin
            rc = $urandom_range(0, 40);
            r  = (rc == 0) ? 1 : rc;
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(1, RC + r + SC);
                do_run(rc, 0, k, 0, 0);
            end else begin
                do_run(rc, 0, 0, 0, 0);
            end
        end

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
